// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding and one-hot light constants for the traffic controller
package traffic_pkg;
    typedef enum logic [2:0] {
        HW_G  = 3'd0,
        HW_Y  = 3'd1,
        AR1   = 3'd2,
        LR_G  = 3'd3,
        LR_Y  = 3'd4,
        AR2   = 3'd5,
        EMERG = 3'd6
    } state_t;
    localparam logic [2:0] GREEN  = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b001;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: per-phase dwell counter; restarts on clear, saturates at dwell-1 while held
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] dwell,
    output logic             done
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;

    assign last = dwell - CNT_W'(1);
    assign done = cnt == last;

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            cnt <= '0;
        else if (!done)
            cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/param_traffic_controller.sv
// param_traffic_controller: highway/local-road light FSM with pedestrian latch and emergency preemption
module param_traffic_controller
    import traffic_pkg::*;
#(
    parameter int unsigned HW_GREEN = 70,
    parameter int unsigned LR_GREEN = 70,
    parameter int unsigned YELLOW   = 25,
    parameter int unsigned ALL_RED  = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lr_has_car,
    input  logic       ped_req,
    input  logic       emergency,
    output logic [2:0] hw_light,
    output logic [2:0] lr_light,
    output logic       ped_walk,
    output logic [2:0] phase
);
    state_t           state, state_d;
    logic             ped_pending, served, done, to_lr;
    logic [CNT_W-1:0] dwell;

    assign to_lr = (state == AR1) && (state_d == LR_G);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= HW_G;
            ped_pending <= 1'b0;
            served      <= 1'b0;
        end else begin
            state <= state_d;
            if (ped_req)
                ped_pending <= 1'b1;
            else if (to_lr)
                ped_pending <= 1'b0;
            if (to_lr)
                served <= ped_pending | ped_req;
        end
    end

    always_comb begin
        dwell = CNT_W'(1);
        case (state)
            HW_G:       dwell = CNT_W'(HW_GREEN);
            LR_G:       dwell = CNT_W'(LR_GREEN);
            HW_Y, LR_Y: dwell = CNT_W'(YELLOW);
            AR1, AR2:   dwell = CNT_W'(ALL_RED);
            default:    dwell = CNT_W'(1);
        endcase
    end

    always_comb begin
        state_d = state;
        if (emergency)
            state_d = EMERG;
        else
            case (state)
                HW_G:    state_d = (done && (lr_has_car || ped_pending)) ? HW_Y : HW_G;
                HW_Y:    state_d = done ? AR1 : HW_Y;
                AR1:     state_d = done ? LR_G : AR1;
                LR_G:    state_d = done ? LR_Y : LR_G;
                LR_Y:    state_d = done ? AR2 : LR_Y;
                AR2:     state_d = done ? HW_G : AR2;
                EMERG:   state_d = AR2;
                default: state_d = HW_G;
            endcase
    end

    // EMERG has no dwell of its own, so keep its counter parked at zero
    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear ((state_d != state) || (state == EMERG)),
        .dwell (dwell),
        .done  (done)
    );

    always_comb begin
        hw_light = state == HW_G ? traffic_pkg::GREEN :
                   state == HW_Y ? traffic_pkg::YELLOW : traffic_pkg::RED;
        lr_light = state == LR_G ? traffic_pkg::GREEN :
                   state == LR_Y ? traffic_pkg::YELLOW : traffic_pkg::RED;
        ped_walk = (state == LR_G) && served;
        phase    = state;
    end
endmodule
